// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one load/store unit between the pipeline MEM stage
// (port 0) and a debug/loader master (port 1).
//
// Each transaction is latched at grant and replayed on the LSU with a stable
// address for RD_LAT cycles, so that loads see valid data and sub-word stores
// (sb/sh) see valid merge data before the single-cycle write strobe.
// Simultaneous requests are served round-robin; port 0 is stalled while it waits.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pN_req/addr/wdata/we/op   request N (held stable until o_pN_done)
//   o_pN_done/err/rdata   one-cycle completion pulse, illegal-store flag, load data
//   o_p0_stall            pipeline stall (i_p0_req & ~o_p0_done)
//   o_lsu_addr/st_data/wren/op  registered LSU drive
//   i_lsu_ld_data         LSU load data
//   o_busy                high whenever the FSM is not IDLE
module lsu_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_p0_req,
   input  logic [31:0] i_p0_addr,
   input  logic [31:0] i_p0_wdata,
   input  logic        i_p0_we,
   input  logic [2:0]  i_p0_op,
   output logic        o_p0_done,
   output logic        o_p0_err,
   output logic [31:0] o_p0_rdata,
   output logic        o_p0_stall,
   input  logic        i_p1_req,
   input  logic [31:0] i_p1_addr,
   input  logic [31:0] i_p1_wdata,
   input  logic        i_p1_we,
   input  logic [2:0]  i_p1_op,
   output logic        o_p1_done,
   output logic        o_p1_err,
   output logic [31:0] o_p1_rdata,
   output logic [31:0] o_lsu_addr,
   output logic [31:0] o_lsu_st_data,
   output logic        o_lsu_wren,
   output logic [2:0]  o_lsu_op,
   input  logic [31:0] i_lsu_ld_data,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

   // Only sb, sh and sw are valid store encodings.
   function automatic logic store_op_legal(input logic [2:0] op);
      case (op)
         3'b000, 3'b001, 3'b010: store_op_legal = 1'b1;
         default:                store_op_legal = 1'b0;
      endcase
   endfunction

   state_t      state_r, state_s;
   logic [2:0]  cnt_r, cnt_s;
   logic        last_grant_r, last_grant_s;
   logic        port_r, port_s;
   logic [31:0] addr_r, addr_s;
   logic [31:0] wdata_r, wdata_s;
   logic        we_r, we_s;
   logic [2:0]  op_r, op_s;
   logic        err_r, err_s;
   logic        sel_s, req_we_s, capture_s, lsu_active_s;
   logic [2:0]  req_op_s;

   logic [31:0] lsu_addr_r, lsu_addr_s;
   logic [31:0] lsu_st_data_r, lsu_st_data_s;
   logic        lsu_wren_r, lsu_wren_s;
   logic [2:0]  lsu_op_r, lsu_op_s;
   logic        busy_r, busy_s;
   logic        done0_r, done0_s, done1_r, done1_s;
   logic        err0_r, err0_s, err1_r, err1_s;
   logic [31:0] rdata0_r, rdata1_r;

   // Next-state, transaction latch and next registered-output logic.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      last_grant_s = last_grant_r;
      port_s       = port_r;
      addr_s       = addr_r;
      wdata_s      = wdata_r;
      we_s         = we_r;
      op_s         = op_r;
      err_s        = err_r;
      capture_s    = 1'b0;

      // Round-robin: on a tie the port that was not served last wins.
      if (i_p0_req && i_p1_req) begin
         sel_s = ~last_grant_r;
      end else if (i_p1_req) begin
         sel_s = 1'b1;
      end else begin
         sel_s = 1'b0;
      end
      req_we_s = sel_s ? i_p1_we : i_p0_we;
      req_op_s = sel_s ? i_p1_op : i_p0_op;

      case (state_r)
         IDLE: begin
            if (i_p0_req || i_p1_req) begin
               port_s  = sel_s;
               addr_s  = sel_s ? i_p1_addr  : i_p0_addr;
               wdata_s = sel_s ? i_p1_wdata : i_p0_wdata;
               we_s    = req_we_s;
               op_s    = req_op_s;
               cnt_s   = 3'd0;
               if (req_we_s && !store_op_legal(req_op_s)) begin
                  err_s   = 1'b1;
                  state_s = DONE;
               end else if (req_we_s && (req_op_s == 3'b010)) begin
                  // Full-word store needs no merge data: write immediately.
                  err_s   = 1'b0;
                  state_s = WRITE;
               end else begin
                  err_s   = 1'b0;
                  state_s = ACCESS;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            cnt_s = cnt_r + 3'd1;
            if (cnt_r == LAST_CNT) begin
               if (we_r) begin
                  state_s = WRITE;
               end else begin
                  capture_s = 1'b1;
                  state_s   = DONE;
               end
            end else begin
               state_s = ACCESS;
            end
         end
         WRITE: begin
            state_s = DONE;
         end
         DONE: begin
            last_grant_s = port_r;
            state_s      = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase

      // Outputs are registered from the next state, so they line up with it.
      lsu_active_s  = (state_s == ACCESS) || (state_s == WRITE);
      lsu_addr_s    = lsu_active_s ? addr_s : 32'd0;
      lsu_op_s      = lsu_active_s ? op_s : 3'd0;
      lsu_wren_s    = (state_s == WRITE);
      lsu_st_data_s = (state_s == WRITE) ? wdata_s : 32'd0;
      busy_s        = (state_s != IDLE);
      done0_s       = (state_s == DONE) && !port_s;
      done1_s       = (state_s == DONE) && port_s;
      err0_s        = done0_s && err_s;
      err1_s        = done1_s && err_s;
   end

   // State, transaction and output registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r       <= IDLE;
         cnt_r         <= 3'd0;
         last_grant_r  <= 1'b1;
         port_r        <= 1'b0;
         addr_r        <= 32'd0;
         wdata_r       <= 32'd0;
         we_r          <= 1'b0;
         op_r          <= 3'd0;
         err_r         <= 1'b0;
         lsu_addr_r    <= 32'd0;
         lsu_st_data_r <= 32'd0;
         lsu_wren_r    <= 1'b0;
         lsu_op_r      <= 3'd0;
         busy_r        <= 1'b0;
         done0_r       <= 1'b0;
         done1_r       <= 1'b0;
         err0_r        <= 1'b0;
         err1_r        <= 1'b0;
         rdata0_r      <= 32'd0;
         rdata1_r      <= 32'd0;
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         last_grant_r  <= last_grant_s;
         port_r        <= port_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
         we_r          <= we_s;
         op_r          <= op_s;
         err_r         <= err_s;
         lsu_addr_r    <= lsu_addr_s;
         lsu_st_data_r <= lsu_st_data_s;
         lsu_wren_r    <= lsu_wren_s;
         lsu_op_r      <= lsu_op_s;
         busy_r        <= busy_s;
         done0_r       <= done0_s;
         done1_r       <= done1_s;
         err0_r        <= err0_s;
         err1_r        <= err1_s;
         // Load data is held per port until that port's next load.
         if (capture_s && !port_r) begin
            rdata0_r <= i_lsu_ld_data;
         end
         if (capture_s && port_r) begin
            rdata1_r <= i_lsu_ld_data;
         end
      end
   end

   assign o_lsu_addr    = lsu_addr_r;
   assign o_lsu_st_data = lsu_st_data_r;
   assign o_lsu_wren    = lsu_wren_r;
   assign o_lsu_op      = lsu_op_r;
   assign o_busy        = busy_r;
   assign o_p0_done     = done0_r;
   assign o_p1_done     = done1_r;
   assign o_p0_err      = err0_r;
   assign o_p1_err      = err1_r;
   assign o_p0_rdata    = rdata0_r;
   assign o_p1_rdata    = rdata1_r;
   assign o_p0_stall    = i_p0_req & ~done0_r;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Self-checking bench for lsu_arbiter with a small word-addressed LSU model.
module tb_lsu_arbiter;

   localparam int RD_LAT = 1;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_p0_req, i_p0_we, i_p1_req, i_p1_we;
   logic [31:0] i_p0_addr, i_p0_wdata, i_p1_addr, i_p1_wdata;
   logic [2:0]  i_p0_op, i_p1_op;
   logic        o_p0_done, o_p0_err, o_p0_stall, o_p1_done, o_p1_err;
   logic [31:0] o_p0_rdata, o_p1_rdata;
   logic [31:0] o_lsu_addr, o_lsu_st_data, i_lsu_ld_data;
   logic        o_lsu_wren, o_busy;
   logic [2:0]  o_lsu_op;

   logic [31:0] mem [0:8191];
   logic        init_mem;
   logic [31:0] rd_word, rd_shift;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 i_clk = ~i_clk;

   lsu_arbiter #(.RD_LAT(RD_LAT)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_p0_req(i_p0_req), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
      .i_p0_we(i_p0_we), .i_p0_op(i_p0_op),
      .o_p0_done(o_p0_done), .o_p0_err(o_p0_err), .o_p0_rdata(o_p0_rdata),
      .o_p0_stall(o_p0_stall),
      .i_p1_req(i_p1_req), .i_p1_addr(i_p1_addr), .i_p1_wdata(i_p1_wdata),
      .i_p1_we(i_p1_we), .i_p1_op(i_p1_op),
      .o_p1_done(o_p1_done), .o_p1_err(o_p1_err), .o_p1_rdata(o_p1_rdata),
      .o_lsu_addr(o_lsu_addr), .o_lsu_st_data(o_lsu_st_data),
      .o_lsu_wren(o_lsu_wren), .o_lsu_op(o_lsu_op),
      .i_lsu_ld_data(i_lsu_ld_data), .o_busy(o_busy)
   );

   // LSU read path: addresses above 0x7FFF are unmapped and read as 0.
   always_comb begin
      rd_word  = mem[o_lsu_addr[14:2]];
      rd_shift = rd_word >> {o_lsu_addr[1:0], 3'b000};
      if (o_lsu_addr[31:15] != 17'd0) begin
         i_lsu_ld_data = 32'd0;
      end else begin
         case (o_lsu_op)
            3'b000:  i_lsu_ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  i_lsu_ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  i_lsu_ld_data = rd_word;
            3'b100:  i_lsu_ld_data = {24'd0, rd_shift[7:0]};
            3'b101:  i_lsu_ld_data = {16'd0, rd_shift[15:0]};
            default: i_lsu_ld_data = 32'd0;
         endcase
      end
   end

   // LSU write path and memory preload.
   always @(posedge i_clk) begin
      if (init_mem) begin
         for (int i = 0; i < 8192; i++) mem[i] <= 32'd0;
         mem[13'h0801] <= 32'hDEADBEEF;
         mem[13'h0802] <= 32'h11223344;
      end else if (o_lsu_wren && (o_lsu_addr[31:15] == 17'd0)) begin
         case (o_lsu_op)
            3'b000: mem[o_lsu_addr[14:2]][{o_lsu_addr[1:0], 3'b000} +: 8] <= o_lsu_st_data[7:0];
            3'b001: mem[o_lsu_addr[14:2]][{o_lsu_addr[1], 4'b0000} +: 16] <= o_lsu_st_data[15:0];
            3'b010: mem[o_lsu_addr[14:2]] <= o_lsu_st_data;
            default: ;
         endcase
      end
   end

   task automatic do_reset();
      @(posedge i_clk); #1;
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      n_checks++;
      if ({o_busy, o_lsu_wren, o_p0_done, o_p1_done, o_p0_err, o_p1_err, o_p0_stall} !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b required 0000000",
                  {o_busy, o_lsu_wren, o_p0_done, o_p1_done, o_p0_err, o_p1_err, o_p0_stall});
      end
      n_checks++;
      if ({o_lsu_addr, o_lsu_st_data, o_lsu_op} !== 67'd0) begin
         n_fail++;
         $display("FAIL reset_lsu: addr %h data %h op %b required all 0", o_lsu_addr, o_lsu_st_data, o_lsu_op);
      end
      n_checks++;
      if ({o_p0_rdata, o_p1_rdata} !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h %h required 0", o_p0_rdata, o_p1_rdata);
      end
   endtask

   // Single-port transaction, checked every cycle against constant expectations.
   task automatic run_txn(input string name, input int port, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic we, input logic [2:0] op,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_cyc);
      exp_t e, got;
      bit   seen;
      logic exp_wren, exp_stall;
      logic [31:0] exp_addr, rd;
      e.port = port; e.rdata = exp_rdata; e.err = exp_err; e.cyc = exp_cyc;
      sb_q.push_back(e);
      @(posedge i_clk); #1;
      if (port == 0) begin
         i_p0_req = 1'b1; i_p0_addr = addr; i_p0_wdata = wdata; i_p0_we = we; i_p0_op = op;
      end else begin
         i_p1_req = 1'b1; i_p1_addr = addr; i_p1_wdata = wdata; i_p1_we = we; i_p1_op = op;
      end
      seen = 1'b0;
      for (int k = 0; k <= exp_cyc + 4 && !seen; k++) begin
         @(negedge i_clk);
         exp_wren  = we && !exp_err && (k == exp_cyc - 1);
         exp_stall = (port == 0) && (k < exp_cyc);
         n_checks++;
         if (o_lsu_wren !== exp_wren) begin
            n_fail++;
            $display("FAIL %s_wren cycle %0d: got %b required %b", name, k, o_lsu_wren, exp_wren);
         end
         n_checks++;
         if (o_p0_stall !== exp_stall) begin
            n_fail++;
            $display("FAIL %s_stall cycle %0d: got %b required %b", name, k, o_p0_stall, exp_stall);
         end
         if (k == 0 || (!exp_err && k < exp_cyc)) begin
            exp_addr = (k == 0) ? 32'd0 : addr;
            n_checks++;
            if (o_lsu_addr !== exp_addr) begin
               n_fail++;
               $display("FAIL %s_addr cycle %0d: got %h required %h", name, k, o_lsu_addr, exp_addr);
            end
         end
         if (o_p0_done || o_p1_done) begin
            seen = 1'b1;
            got  = sb_q.pop_front();
            n_checks++;
            if ((got.port == 0 && (!o_p0_done || o_p1_done)) || (got.port == 1 && (!o_p1_done || o_p0_done))) begin
               n_fail++;
               $display("FAIL %s_port: done p0=%b p1=%b required port %0d only", name, o_p0_done, o_p1_done, got.port);
            end
            n_checks++;
            if (k != got.cyc) begin
               n_fail++;
               $display("FAIL %s_latency: done in cycle %0d required %0d", name, k, got.cyc);
            end
            n_checks++;
            if ((got.port == 0 ? o_p0_err : o_p1_err) !== got.err || (got.port == 0 ? o_p1_err : o_p0_err) !== 1'b0) begin
               n_fail++;
               $display("FAIL %s_err: p0 %b p1 %b required %b on port %0d", name, o_p0_err, o_p1_err, got.err, got.port);
            end
            if (!we) begin
               rd = (got.port == 0) ? o_p0_rdata : o_p1_rdata;
               n_checks++;
               if (rd !== got.rdata) begin
                  n_fail++;
                  $display("FAIL %s_rdata: got %h required %h", name, rd, got.rdata);
               end
            end
         end
      end
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, exp_cyc + 4);
         void'(sb_q.pop_front());
      end
      @(posedge i_clk); #1;
      i_p0_req = 1'b0;
      i_p1_req = 1'b0;
   endtask

   // Simultaneous requests: port 0 lw 0x2004, port 1 lbu 0x2005.
   task automatic run_pair(input string name, input int first);
      exp_t e0, e1, got;
      bit   d0, d1;
      int   c0;
      logic [31:0] rd;
      e0.port = 0; e0.rdata = 32'hDEADBEEF; e0.err = 1'b0;
      e1.port = 1; e1.rdata = 32'h000000BE; e1.err = 1'b0;
      e0.cyc = (first == 0) ? RD_LAT + 1 : 2 * RD_LAT + 3;
      e1.cyc = (first == 1) ? RD_LAT + 1 : 2 * RD_LAT + 3;
      c0 = e0.cyc;
      if (first == 0) begin
         sb_q.push_back(e0); sb_q.push_back(e1);
      end else begin
         sb_q.push_back(e1); sb_q.push_back(e0);
      end
      @(posedge i_clk); #1;
      i_p0_req = 1'b1; i_p0_addr = 32'h2004; i_p0_wdata = 32'd0; i_p0_we = 1'b0; i_p0_op = 3'b010;
      i_p1_req = 1'b1; i_p1_addr = 32'h2005; i_p1_wdata = 32'd0; i_p1_we = 1'b0; i_p1_op = 3'b100;
      d0 = 1'b0; d1 = 1'b0;
      for (int k = 0; k < 16 && !(d0 && d1); k++) begin
         @(negedge i_clk);
         n_checks++;
         if (o_p0_stall !== (k < c0)) begin
            n_fail++;
            $display("FAIL %s_stall cycle %0d: got %b required %b", name, k, o_p0_stall, (k < c0));
         end
         if (o_p0_done || o_p1_done) begin
            got = sb_q.pop_front();
            n_checks++;
            if ((got.port == 0 && (!o_p0_done || o_p1_done)) || (got.port == 1 && (!o_p1_done || o_p0_done))) begin
               n_fail++;
               $display("FAIL %s_order cycle %0d: done p0=%b p1=%b required port %0d", name, k, o_p0_done, o_p1_done, got.port);
            end
            n_checks++;
            if (k != got.cyc) begin
               n_fail++;
               $display("FAIL %s_latency port %0d: done in cycle %0d required %0d", name, got.port, k, got.cyc);
            end
            rd = (got.port == 0) ? o_p0_rdata : o_p1_rdata;
            n_checks++;
            if (rd !== got.rdata) begin
               n_fail++;
               $display("FAIL %s_rdata port %0d: got %h required %h", name, got.port, rd, got.rdata);
            end
            if (o_p0_done) d0 = 1'b1;
            if (o_p1_done) d1 = 1'b1;
         end
         @(posedge i_clk); #1;
         if (d0) i_p0_req = 1'b0;
         if (d1) i_p1_req = 1'b0;
      end
      if (!(d0 && d1)) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: p0 done %b p1 done %b", name, d0, d1);
         sb_q.delete();
         i_p0_req = 1'b0;
         i_p1_req = 1'b0;
      end
   endtask

   task automatic test_lw();
      run_txn("lw", 0, 32'h2004, 32'd0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0, RD_LAT + 1);
   endtask

   task automatic test_sb();
      run_txn("sb", 0, 32'h2008, 32'h000000AA, 1'b1, 3'b000, 32'd0, 1'b0, RD_LAT + 2);
      run_txn("lw_after_sb", 0, 32'h2008, 32'd0, 1'b0, 3'b010, 32'h112233AA, 1'b0, RD_LAT + 1);
   endtask

   task automatic test_both();
      do_reset();
      run_pair("pair_a", 0);
      run_pair("pair_b", 0);
      run_txn("lw_solo", 0, 32'h2004, 32'd0, 1'b0, 3'b010, 32'hDEADBEEF, 1'b0, RD_LAT + 1);
      run_pair("pair_c", 1);
   endtask

   task automatic test_port1_sw();
      run_txn("p1_sw", 1, 32'h7000, 32'h00000005, 1'b1, 3'b010, 32'd0, 1'b0, 2);
      n_checks++;
      if (mem[13'h1C00] !== 32'h00000005) begin
         n_fail++;
         $display("FAIL ledr: got %h required 00000005", mem[13'h1C00]);
      end
   endtask

   task automatic test_illegal();
      run_txn("bad_store", 0, 32'h2004, 32'h12345678, 1'b1, 3'b011, 32'd0, 1'b1, 1);
      run_txn("load_op011", 0, 32'h2004, 32'd0, 1'b0, 3'b011, 32'd0, 1'b0, RD_LAT + 1);
   endtask

   task automatic test_reset_mid();
      int dones;
      @(posedge i_clk); #1;
      i_p0_req = 1'b1; i_p0_addr = 32'h200C; i_p0_wdata = 32'h0000BEEF; i_p0_we = 1'b1; i_p0_op = 3'b001;
      for (int k = 0; k < RD_LAT + 1; k++) begin
         @(posedge i_clk); #1;
      end
      @(negedge i_clk);
      n_checks++;
      if (o_lsu_wren !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid_write: wren got %b required 1", o_lsu_wren);
      end
      i_rst = 1'b1;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      i_p0_req = 1'b0;
      dones = 0;
      @(negedge i_clk);
      n_checks++;
      if ({o_lsu_wren, o_busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL rst_mid_idle: wren %b busy %b required 0 0", o_lsu_wren, o_busy);
      end
      for (int k = 0; k < 4; k++) begin
         if (o_p0_done || o_p1_done) dones++;
         @(negedge i_clk);
      end
      n_checks++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL rst_mid_done: got %0d done pulses required 0", dones);
      end
      run_pair("after_rst", 0);
   endtask

   initial begin
      i_rst = 1'b1; init_mem = 1'b1;
      i_p0_req = 1'b0; i_p0_addr = 32'd0; i_p0_wdata = 32'd0; i_p0_we = 1'b0; i_p0_op = 3'd0;
      i_p1_req = 1'b0; i_p1_addr = 32'd0; i_p1_wdata = 32'd0; i_p1_we = 1'b0; i_p1_op = 3'd0;
      @(posedge i_clk); #1;
      @(posedge i_clk); #1;
      init_mem = 1'b0;
      test_reset();
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      test_lw();
      test_sb();
      test_both();
      test_port1_sw();
      test_illegal();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
